// File: rtl/rattlesnake_fetch_aligner.sv
// Fetch aligner: reads 32-bit words and slices them into 16/32-bit instructions,
// carrying the upper halfword of a word across fetches for compressed/straddling code.
module rattlesnake_fetch_aligner #(
    parameter int PC_BITS = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sync_reset,
    input  logic               start,
    input  logic [PC_BITS-1:0] start_addr,
    input  logic               stall,
    output logic               mem_read_req,
    output logic [PC_BITS-3:0] mem_word_addr,
    input  logic               mem_read_done,
    input  logic [31:0]        mem_data_in,
    output logic               enable_out,
    output logic [31:0]        instruction_out,
    output logic [PC_BITS-1:0] pc_out,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [15:0]        hw_buf_q, hw_buf_d;
    logic               hw_valid_q, hw_valid_d;
    logic               req_d, emit_d;
    logic [PC_BITS-3:0] waddr_d;
    logic [31:0]        instr_d;
    logic [PC_BITS-1:0] epc_d;
    logic [PC_BITS-1:0] pc_plus2, pc_plus4;

    assign pc_plus2 = pc_q + PC_BITS'(2);
    assign pc_plus4 = pc_q + PC_BITS'(4);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hw_buf_d   = hw_buf_q;
        hw_valid_d = hw_valid_q;
        req_d      = 1'b0;
        waddr_d    = mem_word_addr;
        emit_d     = 1'b0;
        instr_d    = instruction_out;
        epc_d      = pc_out;
        if (start) begin
            pc_d       = start_addr & ~PC_BITS'(1);
            hw_valid_d = 1'b0;
            // A read still in flight must be swallowed before the new stream begins
            state_d    = ((state_q == WAIT || state_q == FLUSH) && !mem_read_done) ? FLUSH : REQ;
        end else begin
            case (state_q)
                REQ: if (!stall) begin
                    if (hw_valid_q && hw_buf_q[1:0] != 2'b11) begin
                        emit_d     = 1'b1;
                        instr_d    = {16'h0, hw_buf_q};
                        epc_d      = pc_q;
                        pc_d       = pc_plus2;
                        hw_valid_d = 1'b0;
                    end else begin
                        req_d   = 1'b1;
                        waddr_d = hw_valid_q ? pc_plus2[PC_BITS-1:2] : pc_q[PC_BITS-1:2];
                        state_d = WAIT;
                    end
                end
                WAIT: if (mem_read_done) begin
                    state_d    = REQ;
                    hw_buf_d   = mem_data_in[31:16];
                    hw_valid_d = 1'b1;
                    if (hw_valid_q) begin
                        emit_d  = 1'b1;
                        instr_d = {mem_data_in[15:0], hw_buf_q};
                        epc_d   = pc_q;
                        pc_d    = pc_plus4;
                    end else if (!pc_q[1]) begin
                        emit_d = 1'b1;
                        epc_d  = pc_q;
                        if (mem_data_in[1:0] == 2'b11) begin
                            instr_d    = mem_data_in;
                            pc_d       = pc_plus4;
                            hw_valid_d = 1'b0;
                        end else begin
                            instr_d = {16'h0, mem_data_in[15:0]};
                            pc_d    = pc_plus2;
                        end
                    end
                end
                FLUSH: if (mem_read_done) state_d = REQ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            hw_buf_q        <= '0;
            hw_valid_q      <= 1'b0;
            mem_read_req    <= 1'b0;
            mem_word_addr   <= '0;
            enable_out      <= 1'b0;
            instruction_out <= '0;
            pc_out          <= '0;
        end else if (sync_reset) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            hw_buf_q        <= '0;
            hw_valid_q      <= 1'b0;
            mem_read_req    <= 1'b0;
            mem_word_addr   <= '0;
            enable_out      <= 1'b0;
            instruction_out <= '0;
            pc_out          <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            hw_buf_q        <= hw_buf_d;
            hw_valid_q      <= hw_valid_d;
            mem_read_req    <= req_d;
            mem_word_addr   <= waddr_d;
            enable_out      <= emit_d;
            instruction_out <= instr_d;
            pc_out          <= epc_d;
        end
    end

endmodule

// File: tb/tb_rattlesnake_fetch_aligner.sv
// Bench for rattlesnake_fetch_aligner: memory responder plus scoreboards of
// expected read addresses and emitted instructions.
module tb_rattlesnake_fetch_aligner;

    logic        clk, reset_n, sync_reset, start, stall;
    logic [31:0] start_addr;
    logic        mem_read_req, mem_read_done;
    logic [29:0] mem_word_addr;
    logic [31:0] mem_data_in;
    logic        enable_out, busy;
    logic [31:0] instruction_out, pc_out;

    rattlesnake_fetch_aligner #(.PC_BITS(32)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .start(start),
        .start_addr(start_addr), .stall(stall), .mem_read_req(mem_read_req),
        .mem_word_addr(mem_word_addr), .mem_read_done(mem_read_done),
        .mem_data_in(mem_data_in), .enable_out(enable_out),
        .instruction_out(instruction_out), .pc_out(pc_out), .busy(busy)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } emit_t;

    emit_t       exp_q[$];
    logic [29:0] exp_req[$];
    logic [31:0] mem [logic [29:0]];
    int          checks = 0;
    int          errors = 0;
    int          n_req = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [29:0] pend_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0013;
    endfunction

    // Memory model: one outstanding read, answered mem_lat cycles after the request
    initial begin
        logic [29:0] a;
        mem_read_done = 1'b0;
        mem_data_in   = '0;
        forever begin
            @(negedge clk);
            mem_read_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_read_done = 1'b1;
                    mem_data_in   = mem_rd(pend_addr);
                end
            end
            if (mem_read_req === 1'b1) begin
                n_req++;
                pend_addr = mem_word_addr;
                pend_cnt  = mem_lat;
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got request 0x%h, required none", mem_word_addr);
                end else begin
                    a = exp_req.pop_front();
                    if (mem_word_addr !== a) begin
                        errors++;
                        $display("FAIL req_addr: got 0x%h, required 0x%h", mem_word_addr, a);
                    end
                end
            end
        end
    end

    initial begin
        emit_t e;
        forever begin
            @(negedge clk);
            if (enable_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL emit_unexpected: got 0x%h @0x%h, required none", instruction_out, pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (instruction_out !== e.instr || pc_out !== e.pc) begin
                        errors++;
                        $display("FAIL emit: got 0x%h @0x%h, required 0x%h @0x%h",
                                 instruction_out, pc_out, e.instr, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_emit(input logic [31:0] instr, input logic [31:0] pc);
        emit_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] addr);
        @(negedge clk); #1;
        start = 1'b1;
        start_addr = addr;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_req(input int n0);
        int c = 0;
        while (n_req == n0 && c < 30) begin
            @(negedge clk); #1;
            c++;
        end
    endtask

    task automatic finish_test(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || exp_req.size() != 0) && c < 300) begin
            @(negedge clk); #1;
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_req.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d emits and %0d requests outstanding, required 0",
                     name, exp_q.size(), exp_req.size());
            exp_q.delete();
            exp_req.delete();
        end
        sync_reset = 1'b1;
        @(negedge clk); #1;
        sync_reset = 1'b0;
        stall = 1'b0;
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (enable_out !== 1'b0 || mem_read_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got en=%b req=%b, required 0 0", enable_out, mem_read_req);
        end
        checks++;
        if (instruction_out !== 32'h0 || pc_out !== 32'h0 || mem_word_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_data: got instr=0x%h pc=0x%h waddr=0x%h, required all 0",
                     instruction_out, pc_out, mem_word_addr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
        sync_reset = 1'b1;
        start = 1'b1;
        start_addr = 32'h100;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || mem_read_req !== 1'b0) begin
            errors++;
            $display("FAIL sync_reset_priority: got busy=%b req=%b, required 0 0", busy, mem_read_req);
        end
        sync_reset = 1'b0;
        start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sync_reset_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_word_fetch();
        mem_lat = 1;
        mem[30'h40] = 32'h00A0_0093;
        exp_req.push_back(30'h40);
        push_emit(32'h00A0_0093, 32'h100);
        exp_req.push_back(30'h41);
        do_start(32'h100);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL word_busy: got %b, required 1", busy);
        end
        finish_test("word_fetch");
    endtask

    task automatic test_compressed_pair();
        mem_lat = 2;
        mem[30'h80] = 32'h4501_4505;
        exp_req.push_back(30'h80);
        push_emit(32'h0000_4505, 32'h200);
        push_emit(32'h0000_4501, 32'h202);
        exp_req.push_back(30'h81);
        do_start(32'h201);
        finish_test("compressed_pair");
    endtask

    task automatic test_straddle();
        mem_lat = 1;
        mem[30'hC0] = 32'h0093_1234;
        mem[30'hC1] = 32'h4505_00A0;
        exp_req.push_back(30'hC0);
        exp_req.push_back(30'hC1);
        push_emit(32'h00A0_0093, 32'h302);
        push_emit(32'h0000_4505, 32'h306);
        exp_req.push_back(30'hC2);
        do_start(32'h302);
        finish_test("straddle");
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        mem[30'h3FFF_FFFF] = 32'h0093_5678;
        mem[30'h0] = 32'h4505_00A0;
        exp_req.push_back(30'h3FFF_FFFF);
        exp_req.push_back(30'h0);
        push_emit(32'h00A0_0093, 32'hFFFF_FFFE);
        push_emit(32'h0000_4505, 32'h2);
        exp_req.push_back(30'h1);
        do_start(32'hFFFF_FFFE);
        finish_test("wrap");
    endtask

    task automatic test_redirect();
        int n0;
        mem_lat = 4;
        mem[30'h40] = 32'h00A0_0093;
        exp_req.push_back(30'h40);
        exp_req.push_back(30'h100);
        n0 = n_req;
        do_start(32'h100);
        wait_req(n0);
        start = 1'b1;
        start_addr = 32'h400;
        @(negedge clk); #1;
        start = 1'b0;
        finish_test("redirect");
    endtask

    task automatic test_stall();
        int n0;
        mem_lat = 2;
        mem[30'h140] = 32'h00A0_0093;
        stall = 1'b1;
        do_start(32'h500);
        n0 = n_req;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (n_req !== n0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got %0d requests busy=%b, required 0 requests busy=1", n_req - n0, busy);
        end
        exp_req.push_back(30'h140);
        push_emit(32'h00A0_0093, 32'h500);
        stall = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (n_req !== n0 + 1) begin
            errors++;
            $display("FAIL stall_release: got %0d requests, required 1", n_req - n0);
        end
        // stall in WAIT must not block the response
        stall = 1'b1;
        finish_test("stall");
    endtask

    task automatic test_async_reset();
        int n0;
        mem_lat = 3;
        mem[30'h180] = 32'h00A0_0093;
        exp_req.push_back(30'h180);
        n0 = n_req;
        do_start(32'h600);
        wait_req(n0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_read_req !== 1'b0 || enable_out !== 1'b0 ||
            mem_word_addr !== 30'h0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got busy=%b req=%b en=%b waddr=0x%h pc=0x%h instr=0x%h, required all 0",
                     busy, mem_read_req, enable_out, mem_word_addr, pc_out, instruction_out);
        end
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || mem_read_req !== 1'b0 || enable_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_late_done: got busy=%b req=%b en=%b, required 0 0 0",
                     busy, mem_read_req, enable_out);
        end
        finish_test("async_reset");
    endtask

    initial begin
        reset_n    = 1'b0;
        sync_reset = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        stall      = 1'b0;
        test_reset();
        test_word_fetch();
        test_compressed_pair();
        test_straddle();
        test_wrap();
        test_redirect();
        test_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
